// File: rtl/reaction_stats_if.sv
// Result/statistics bundle between the reaction-timer core and the stats block.
// master: drives result_valid/result_d*, reads ave_d*/best_d*/count/busy/stats_valid/overrun.
interface reaction_stats_if #(
    parameter int DEPTH_LOG2 = 2
);
    logic                  result_valid;
    logic [3:0]            result_d3;
    logic [3:0]            result_d2;
    logic [3:0]            result_d1;
    logic [3:0]            result_d0;
    logic [3:0]            ave_d3;
    logic [3:0]            ave_d2;
    logic [3:0]            ave_d1;
    logic [3:0]            ave_d0;
    logic [3:0]            best_d3;
    logic [3:0]            best_d2;
    logic [3:0]            best_d1;
    logic [3:0]            best_d0;
    logic [DEPTH_LOG2:0]   count;
    logic                  busy;
    logic                  stats_valid;
    logic                  overrun;

    modport master (
        output result_valid, result_d3, result_d2, result_d1, result_d0,
        input  ave_d3, ave_d2, ave_d1, ave_d0,
        input  best_d3, best_d2, best_d1, best_d0,
        input  count, busy, stats_valid, overrun
    );

    modport slave (
        input  result_valid, result_d3, result_d2, result_d1, result_d0,
        output ave_d3, ave_d2, ave_d1, ave_d0,
        output best_d3, best_d2, best_d1, best_d0,
        output count, busy, stats_valid, overrun
    );
endinterface

// File: rtl/reaction_stats.sv
// Windowed mean and all-time best of BCD reaction times (cs, 0000-9999).
// Ports: clock, reset (sync, active-low), bus (reaction_stats_if.slave);
// optional `clear` input when REACTION_STATS_CLEAR_EN is defined.
module reaction_stats #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic clock,
    input  logic reset,
`ifdef REACTION_STATS_CLEAR_EN
    input  logic clear,
`endif
    reaction_stats_if.slave bus
);
    localparam int WIN = 1 << DEPTH_LOG2;
    localparam int SW  = 14 + DEPTH_LOG2;
    localparam int CW  = DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE, CONV, ACCUM, DIV, BCD, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      step_q;
    logic [15:0]     dig_q;
    logic [13:0]     bin_q;
    logic [SW-1:0]   sum_q;
    logic [13:0]     buf_q [WIN];
    logic [DEPTH_LOG2-1:0] ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [13:0]     best_bin_q;
    logic [15:0]     best_dig_q;
    logic [SW-1:0]   quo_q;
    logic [CW-1:0]   rem_q;
    logic [15:0]     bcd_q;
    logic [15:0]     ave_q;
    logic [15:0]     best_q;
    logic [CW-1:0]   count_q;
    logic            ovr_q;

    logic            clr_w;
    logic            accept;
    logic            do_clear;
    logic            full;
    logic [13:0]     bin_w;
    logic [SW-1:0]   sum_nx;
    logic [CW:0]     trial;
    logic [15:0]     adj;
    logic [15:0]     bcd_nx;
    logic            busy_w;
    logic            sv_w;

`ifdef REACTION_STATS_CLEAR_EN
    assign clr_w = clear;
`else
    assign clr_w = 1'b0;
`endif

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign accept   = (state_q == IDLE) && bus.result_valid && !clr_w;
    assign do_clear = (state_q == IDLE) && clr_w;
    assign full     = (cnt_q == CW'(WIN));

    // Datapath combinational helpers
    always_comb begin
        bin_w = 14'({10'd0, dig_q[15:12]}) * 14'd1000
              + 14'({10'd0, dig_q[11:8]})  * 14'd100
              + 14'({10'd0, dig_q[7:4]})   * 14'd10
              + 14'({10'd0, dig_q[3:0]});
        sum_nx = sum_q + SW'(bin_q);
        if (full)
            sum_nx = sum_nx - SW'(buf_q[ptr_q]);
        trial = {rem_q, quo_q[SW-1]};
        // Double-dabble: +3 on any digit >= 5 before each shift
        for (int i = 0; i < 4; i++) begin
            adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5)
                          ? bcd_q[i*4 +: 4] + 4'd3
                          : bcd_q[i*4 +: 4];
        end
        bcd_nx = {adj[14:0], quo_q[13]};
    end

    // FSM: state register
    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CONV;
            CONV:    state_d = ACCUM;
            ACCUM:   state_d = DIV;
            DIV:     if (step_q == 5'(SW - 1)) state_d = BCD;
            BCD:     if (step_q == 5'd13) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs (busy also covers the accept cycle itself)
    always_comb begin
        busy_w = (state_q != IDLE) || accept;
        sv_w   = (state_q == DONE);
    end

    // Ring buffer needs no reset: entries beyond count are never read
    always_ff @(posedge clock) begin
        if (state_q == ACCUM)
            buf_q[ptr_q] <= bin_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            step_q     <= '0;
            dig_q      <= '0;
            bin_q      <= '0;
            sum_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            best_bin_q <= '0;
            best_dig_q <= 16'hCCCC;
            quo_q      <= '0;
            rem_q      <= '0;
            bcd_q      <= '0;
            ave_q      <= 16'hCCCC;
            best_q     <= 16'hCCCC;
            count_q    <= '0;
            ovr_q      <= 1'b0;
        end else begin
            if (state_q != IDLE && bus.result_valid)
                ovr_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (do_clear) begin
                        sum_q      <= '0;
                        ptr_q      <= '0;
                        cnt_q      <= '0;
                        best_dig_q <= 16'hCCCC;
                        ave_q      <= 16'hCCCC;
                        best_q     <= 16'hCCCC;
                        count_q    <= '0;
                    end else if (accept) begin
                        dig_q <= {clamp9(bus.result_d3),
                                  clamp9(bus.result_d2),
                                  clamp9(bus.result_d1),
                                  clamp9(bus.result_d0)};
                    end
                end
                CONV: bin_q <= bin_w;
                ACCUM: begin
                    sum_q <= sum_nx;
                    ptr_q <= ptr_q + 1'b1;
                    if (!full)
                        cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '0 || bin_q < best_bin_q) begin
                        best_bin_q <= bin_q;
                        best_dig_q <= dig_q;
                    end
                    quo_q  <= sum_nx;
                    rem_q  <= '0;
                    step_q <= '0;
                end
                DIV: begin
                    // Restoring step; divisor is the post-increment count
                    if (trial >= {1'b0, cnt_q}) begin
                        rem_q <= CW'(trial - {1'b0, cnt_q});
                        quo_q <= {quo_q[SW-2:0], 1'b1};
                    end else begin
                        rem_q <= trial[CW-1:0];
                        quo_q <= {quo_q[SW-2:0], 1'b0};
                    end
                    if (step_q == 5'(SW - 1)) begin
                        step_q <= '0;
                        bcd_q  <= '0;
                    end else begin
                        step_q <= step_q + 5'd1;
                    end
                end
                BCD: begin
                    bcd_q  <= bcd_nx;
                    quo_q  <= quo_q << 1;
                    step_q <= step_q + 5'd1;
                    // Publish on the last shift so outputs are live in DONE
                    if (step_q == 5'd13) begin
                        ave_q   <= bcd_nx;
                        best_q  <= best_dig_q;
                        count_q <= cnt_q;
                    end
                end
                DONE: step_q <= '0;
                default: step_q <= '0;
            endcase
        end
    end

    assign bus.ave_d3      = ave_q[15:12];
    assign bus.ave_d2      = ave_q[11:8];
    assign bus.ave_d1      = ave_q[7:4];
    assign bus.ave_d0      = ave_q[3:0];
    assign bus.best_d3     = best_q[15:12];
    assign bus.best_d2     = best_q[11:8];
    assign bus.best_d1     = best_q[7:4];
    assign bus.best_d0     = best_q[3:0];
    assign bus.count       = count_q;
    assign bus.busy        = busy_w;
    assign bus.stats_valid = sv_w;
    assign bus.overrun     = ovr_q;
endmodule
